// File: rtl/hub_link.sv
// Byte-serial link between a hashing core and an async UART pair: work units
// are streamed out LSB byte first, golden nonces are assembled from received bytes.
module hub_link #(
    parameter int WORK_BYTES  = 44,
    parameter int NONCE_BYTES = 4,
    parameter int RX_TIMEOUT  = 1048576
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic [8*WORK_BYTES-1:0]  work_data,
    input  logic                     work_valid,
    output logic                     work_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    output logic [8*NONCE_BYTES-1:0] nonce,
    output logic                     nonce_valid,
    output logic                     rx_timeout_err,
    output logic [1:0]               tx_state
);

    localparam int BCW = (WORK_BYTES > 1) ? $clog2(WORK_BYTES) : 1;
    localparam int RCW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
    localparam int TW  = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    // Handshake: a work unit transfers on a rising edge where work_valid and
    // work_ready are both high; work_ready is high only in IDLE once armed.
    tx_state_t               state, state_next;
    logic [8*WORK_BYTES-1:0] shift;
    logic [BCW-1:0]          byte_cnt;
    logic                    armed;
    logic                    accept;
    logic                    last_byte;

    assign accept    = work_valid && work_ready;
    assign last_byte = (byte_cnt == BCW'(WORK_BYTES - 1));
    assign tx_data   = shift[7:0];
    assign tx_state  = state;

    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // armed keeps work_ready low until the first clock edge after reset release
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            shift    <= '0;
            byte_cnt <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                shift    <= work_data;
                byte_cnt <= '0;
            end else if (state == WAIT_LO && !tx_busy) begin
                shift    <= shift >> 8;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        work_ready = 1'b0;
        tx_start   = 1'b0;
        case (state)
            IDLE: begin
                work_ready = armed;
                if (work_valid && armed) state_next = STROBE;
            end
            STROBE: begin
                tx_start   = 1'b1;
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) state_next = last_byte ? IDLE : STROBE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic [8*NONCE_BYTES-1:0] asm_q;
    logic [8*NONCE_BYTES-1:0] asm_next;
    logic [RCW-1:0]           rx_cnt;
    logic [TW-1:0]            timer;
    logic                     expired;
    logic                     last_rx;

    assign expired = (rx_cnt != '0) && (timer == TW'(RX_TIMEOUT));
    assign last_rx = (rx_cnt == RCW'(NONCE_BYTES - 1));

    always_comb begin
        asm_next                 = asm_q;
        asm_next[8*rx_cnt +: 8]  = rx_data;
    end

    // An arriving byte takes priority over timer expiry in the same cycle.
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            asm_q          <= '0;
            rx_cnt         <= '0;
            timer          <= '0;
            nonce          <= '0;
            nonce_valid    <= 1'b0;
            rx_timeout_err <= 1'b0;
        end else begin
            nonce_valid    <= 1'b0;
            rx_timeout_err <= 1'b0;
            if (rx_ready) begin
                asm_q <= asm_next;
                timer <= '0;
                if (last_rx) begin
                    nonce       <= asm_next;
                    nonce_valid <= 1'b1;
                    rx_cnt      <= '0;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else if (expired) begin
                rx_cnt         <= '0;
                timer          <= '0;
                rx_timeout_err <= 1'b1;
            end else if (rx_cnt != '0) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hub_link.sv
// Bench for hub_link: transmitter model with 10-cycle busy, byte and nonce
// scoreboards, timeout boundaries, reset mid-transfer, concurrent traffic.
module tb_hub_link;

    localparam int WB = 44;
    localparam int NB = 4;
    localparam int TO = 16;

    logic            hash_clk = 1'b0;
    logic            reset_n;
    logic [8*WB-1:0] work_data;
    logic            work_valid;
    logic            work_ready;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic [7:0]      rx_data;
    logic            rx_ready;
    logic [8*NB-1:0] nonce;
    logic            nonce_valid;
    logic            rx_timeout_err;
    logic [1:0]      tx_state;

    hub_link #(.WORK_BYTES(WB), .NONCE_BYTES(NB), .RX_TIMEOUT(TO)) dut (
        .hash_clk       (hash_clk),
        .reset          (reset_n),
        .work_data      (work_data),
        .work_valid     (work_valid),
        .work_ready     (work_ready),
        .tx_data        (tx_data),
        .tx_start       (tx_start),
        .tx_busy        (tx_busy),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .nonce          (nonce),
        .nonce_valid    (nonce_valid),
        .rx_timeout_err (rx_timeout_err),
        .tx_state       (tx_state)
    );

    always #5 hash_clk = ~hash_clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_exp_q[$];
    logic [31:0] nonce_exp_q[$];
    int          unit_bytes = 0;
    int          err_pulses = 0;
    int          nonce_pulses = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Transmitter model: busy for 10 cycles after every strobe.
    initial begin : tx_model
        logic [7:0] cur;
        bit         skip;
        tx_busy = 1'b0;
        skip    = 1'b0;
        forever begin
            if (!skip) @(negedge hash_clk);
            skip = 1'b0;
            if (reset_n && tx_start) begin
                cur = tx_data;
                check("tx_strobe_expected", 64'(tx_exp_q.size() != 0), 1);
                if (tx_exp_q.size() != 0) check("tx_byte", cur, tx_exp_q.pop_front());
                unit_bytes++;
                tx_busy = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge hash_clk);
                    if (!reset_n) break;
                    check("tx_start_pulse", tx_start, 0);
                    check("tx_data_stable", tx_data, cur);
                end
                tx_busy = 1'b0;
                if (!reset_n) begin
                    unit_bytes = 0;
                end else begin
                    @(negedge hash_clk);
                    if (!reset_n) begin
                        unit_bytes = 0;
                    end else if (unit_bytes < WB) begin
                        check("tx_no_gap", tx_start, 1);
                        skip = 1'b1;
                    end else begin
                        check("ready_after_last", work_ready, 1);
                        unit_bytes = 0;
                    end
                end
            end
        end
    end

    initial begin : rx_monitor
        forever begin
            @(negedge hash_clk);
            if (rx_timeout_err) err_pulses++;
            if (nonce_valid) begin
                nonce_pulses++;
                check("nonce_expected", 64'(nonce_exp_q.size() != 0), 1);
                if (nonce_exp_q.size() != 0) check("nonce_value", nonce, nonce_exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge hash_clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_nonce(input logic [31:0] n, input int gap);
        nonce_exp_q.push_back(n);
        for (int i = 0; i < NB; i++) send_rx(n[8*i +: 8]);
        repeat (gap) @(negedge hash_clk);
    endtask

    task automatic drive_work(input logic [8*WB-1:0] d, input bit keep);
        bit got = 1'b0;
        work_data  = d;
        work_valid = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (work_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge hash_clk);
        end
        check("work_accepted", 64'(got), 1);
        if (got) for (int i = 0; i < WB; i++) tx_exp_q.push_back(d[8*i +: 8]);
        @(negedge hash_clk);
        if (!keep) work_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        for (int c = 0; c < 4000; c++) begin
            if (tx_exp_q.size() == 0 && work_ready) break;
            @(negedge hash_clk);
        end
        check("tx_drained", 64'(tx_exp_q.size()), 0);
        check("tx_idle_ready", work_ready, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_work_ready", work_ready, 0);
        check("rst_nonce", nonce, 0);
        check("rst_nonce_valid", nonce_valid, 0);
        check("rst_timeout_err", rx_timeout_err, 0);
        check("rst_tx_state", tx_state, 0);
    endtask

    logic [8*WB-1:0] wa, wb;
    int e0, p0;

    initial begin : main
        reset_n    = 1'b0;
        work_valid = 1'b0;
        work_data  = '0;
        rx_data    = '0;
        rx_ready   = 1'b0;
        repeat (3) @(negedge hash_clk);
        check_reset_outputs();
        reset_n = 1'b1;
        check("ready_before_edge", work_ready, 0);
        @(negedge hash_clk);
        check("ready_after_reset", work_ready, 1);

        // One work unit with bytes 0x00..0x2B
        for (int i = 0; i < WB; i++) wa[8*i +: 8] = 8'(i);
        drive_work(wa, 1'b0);
        wait_tx_idle();

        // One nonce
        p0 = nonce_pulses;
        send_nonce(32'hDEADBEEF, 2);
        check("nonce_one_pulse", 64'(nonce_pulses - p0), 1);

        // Timeout then recovery
        e0 = err_pulses;
        p0 = nonce_pulses;
        send_rx(8'h11);
        send_rx(8'h22);
        repeat (20) @(negedge hash_clk);
        check("timeout_one_err", 64'(err_pulses - e0), 1);
        check("timeout_nonce_hold", nonce, 32'hDEADBEEF);
        check("timeout_no_valid", 64'(nonce_pulses - p0), 0);
        send_nonce(32'h04030201, 2);
        check("recovery_nonce", nonce, 32'h04030201);

        // Byte arriving in the exact expiry cycle wins
        e0 = err_pulses;
        nonce_exp_q.push_back(32'hDDCCBBAA);
        send_rx(8'hAA);
        repeat (TO) @(negedge hash_clk);
        send_rx(8'hBB);
        send_rx(8'hCC);
        send_rx(8'hDD);
        repeat (2) @(negedge hash_clk);
        check("coincide_no_err", 64'(err_pulses - e0), 0);
        check("coincide_nonce", nonce, 32'hDDCCBBAA);

        // One cycle later the partial is dropped and the late byte starts afresh
        e0 = err_pulses;
        nonce_exp_q.push_back(32'h99887766);
        send_rx(8'h55);
        repeat (TO + 1) @(negedge hash_clk);
        send_rx(8'h66);
        send_rx(8'h77);
        send_rx(8'h88);
        send_rx(8'h99);
        repeat (2) @(negedge hash_clk);
        check("late_byte_err", 64'(err_pulses - e0), 1);
        check("late_byte_nonce", nonce, 32'h99887766);

        // Reset after byte 20 with two nonce bytes buffered
        for (int i = 0; i < WB; i++) wb[8*i +: 8] = 8'($urandom_range(0, 255));
        drive_work(wb, 1'b0);
        for (int c = 0; c < 2000 && unit_bytes < 20; c++) @(negedge hash_clk);
        check("reached_byte_20", 64'(unit_bytes >= 20), 1);
        send_rx(8'hA5);
        send_rx(8'h5A);
        reset_n = 1'b0;
        tx_exp_q.delete();
        repeat (2) @(negedge hash_clk);
        check_reset_outputs();
        reset_n = 1'b1;
        @(negedge hash_clk);
        check("ready_after_mid_reset", work_ready, 1);
        repeat (40) @(negedge hash_clk);
        check("idle_after_mid_reset", tx_state, 0);
        send_nonce(32'h40302010, 2);
        check("fresh_nonce", nonce, 32'h40302010);

        // Back-to-back work with nonces streaming in parallel
        e0 = err_pulses;
        for (int i = 0; i < WB; i++) begin
            wa[8*i +: 8] = 8'($urandom_range(0, 255));
            wb[8*i +: 8] = 8'($urandom_range(0, 255));
        end
        fork
            begin
                drive_work(wa, 1'b1);
                drive_work(wb, 1'b0);
            end
            begin
                for (int k = 0; k < 30; k++)
                    send_nonce($urandom_range(0, 32'h7fffffff), $urandom_range(1, 12));
            end
        join
        wait_tx_idle();
        check("concurrent_no_err", 64'(err_pulses - e0), 0);

        repeat (5) @(negedge hash_clk);
        check("tx_queue_empty", 64'(tx_exp_q.size()), 0);
        check("nonce_queue_empty", 64'(nonce_exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
